apb_req_master: RTL and testbench

//  Upstream APB master feeding apb_dpmem. Accepts simple valid/ready commands (addr/write/wdata/strb),

---
 rtl/apb_req_master_if.sv | 48 ++++
 rtl/apb_req_master.sv | 147 ++++++++++++++
 tb/tb_apb_req_master.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_if.sv
// Command, response and APB completer signals shared by apb_req_master and its neighbours.
interface apb_req_master_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  // command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_write;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;
  // response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  // APB bus
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_req_master.sv
// APB requester: turns valid/ready commands into APB SETUP/ACCESS transfers and
// returns one response per command through a 2-entry in-order response FIFO.
module apb_req_master #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_req_master_if.master  bus
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;

  rsp_t                  fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  xfer_done_c, wd_expire_c, push_c, pop_c, accept_c, cmd_ready_c;
  logic [2:0]            occ_next_c;
  rsp_t                  rsp_in_c;

  // Completion, watchdog expiry, FIFO occupancy and command acceptance.
  always_comb begin
    xfer_done_c = (state_q == S_ACCESS) && bus.PREADY;
    wd_expire_c = (TIMEOUT_CYCLES != 0) && (state_q == S_ACCESS) && !bus.PREADY &&
                  (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
    push_c      = xfer_done_c || wd_expire_c;
    pop_c       = (count_q != 2'd0) && bus.rsp_ready;
    occ_next_c  = 3'(count_q) + 3'(push_c) - 3'(pop_c);
    cmd_ready_c = ((state_q == S_IDLE) || xfer_done_c) && (occ_next_c < 3'd2) && !PRESET;
    accept_c    = bus.cmd_valid && cmd_ready_c;
    // An aborted transfer reports zero data with both error flags set.
    rsp_in_c.rdata   = (xfer_done_c && !pwrite_q) ? bus.PRDATA : '0;
    rsp_in_c.err     = xfer_done_c ? bus.PSLVERR : 1'b1;
    rsp_in_c.timeout = !xfer_done_c;
  end

  // Next-state and registered APB outputs.
  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    wdog_d    = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (xfer_done_c) begin
          state_d = accept_c ? S_SETUP : S_IDLE;
        end else if (wd_expire_c) begin
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Command fields are captured only on the acceptance edge.
    if (accept_c) begin
      wdog_d   = '0;
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
      pstrb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
    end
    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
  end

  // FSM and APB output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      wdog_q    <= wdog_d;
    end
  end

  // Response FIFO: two entries, in order; cmd_ready gating keeps pushes off a full FIFO.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= rsp_in_c;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      count_q <= 2'(occ_next_c);
    end
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.rsp_valid   = (count_q != 2'd0);
  assign bus.rsp_rdata   = fifo_q[rd_ptr_q].rdata;
  assign bus.rsp_err     = fifo_q[rd_ptr_q].err;
  assign bus.rsp_timeout = fifo_q[rd_ptr_q].timeout;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: APB completer model plus response scoreboard.
module tb_apb_req_master;
  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned TMO = 16;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_req_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

  apb_req_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  // n_wait = ACCESS cycle on which the completer raises PREADY; 0 = never.
  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            n_wait;
    logic [DW-1:0] prdata;
    logic          err;
  } plan_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          timeout;
  } exp_t;

  plan_t plan_q[$];
  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    b2b_cnt = 0;
  int    acc_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic plan_t mk(input logic [AW-1:0] addr, input logic write,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                               input int n_wait, input logic [DW-1:0] prdata, input logic err);
    plan_t p;
    p.addr = addr; p.write = write; p.wdata = wdata; p.strb = strb;
    p.n_wait = n_wait; p.prdata = prdata; p.err = err;
    return p;
  endfunction

  function automatic exp_t expect_of(input plan_t p);
    exp_t e;
    e.timeout = (p.n_wait == 0);
    e.err     = (p.n_wait == 0) ? 1'b1 : p.err;
    e.rdata   = (p.write || p.n_wait == 0) ? '0 : p.prdata;
    return e;
  endfunction

  // APB completer: checks bus phases and signal stability, answers per plan.
  plan_t cur;
  bit    active = 0, done_seen = 0;
  int    phase_prev = 0, setup_run = 0;
  always @(posedge PCLK) begin
    #1;
    if (PRESET) begin
      active = 0; done_seen = 0; acc_cnt = 0; phase_prev = 0; setup_run = 0;
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    end else if (bus.PSEL && !bus.PENABLE) begin
      if (phase_prev != 1) begin
        if (active) check("done_before_setup", 64'(done_seen), 1);
        if (phase_prev == 2) b2b_cnt++;
        check("plan_avail", 64'(plan_q.size()), 1);
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        check("setup_paddr", 64'(bus.PADDR), 64'(cur.addr));
        check("setup_pwrite", 64'(bus.PWRITE), 64'(cur.write));
        check("setup_pwdata", 64'(bus.PWDATA), cur.write ? 64'(cur.wdata) : 64'(0));
        check("setup_pstrb", 64'(bus.PSTRB), cur.write ? 64'(cur.strb) : 64'(0));
        active = 1; done_seen = 0; acc_cnt = 0; setup_run = 1;
      end else begin
        setup_run++;
      end
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
      phase_prev = 1;
    end else if (bus.PSEL && bus.PENABLE) begin
      if (acc_cnt == 0) check("setup_len", 64'(setup_run), 1);
      acc_cnt++;
      check("access_paddr", 64'(bus.PADDR), 64'(cur.addr));
      check("access_pwdata", 64'(bus.PWDATA), cur.write ? 64'(cur.wdata) : 64'(0));
      bus.PRDATA = cur.prdata;
      if (cur.n_wait != 0 && acc_cnt == cur.n_wait) begin
        bus.PREADY = 1'b1; bus.PSLVERR = cur.err; done_seen = 1;
      end else begin
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
      end
      phase_prev = 2;
    end else begin
      if (active) begin
        if (!done_seen) check("wdog_access_cycles", 64'(acc_cnt), 64'(TMO));
        active = 0;
      end
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
      phase_prev = 0;
    end
  end

  // Response monitor: every popped response is compared against the scoreboard head.
  always @(negedge PCLK) begin
    if (!PRESET && bus.rsp_valid && bus.rsp_ready) begin
      check("rsp_pending", 64'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.timeout));
      end
    end
  end

  // Offers one command; entered and left just after a rising edge.
  task automatic send(input plan_t p);
    bit ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = p.addr;
    bus.cmd_write = p.write;
    bus.cmd_wdata = p.wdata;
    bus.cmd_strb  = p.strb;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge PCLK);
      if (bus.cmd_ready) begin
        ok = 1;
        plan_q.push_back(p);
        sb_q.push_back(expect_of(p));
      end
      @(posedge PCLK);
      #1;
    end
    check("cmd_accepted", 64'(ok), 1);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_write = 1'($urandom);
    bus.cmd_wdata = DW'($urandom);
    bus.cmd_strb  = SW'($urandom);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (sb_q.size() == 0 && !bus.rsp_valid) break;
      @(posedge PCLK);
      #1;
    end
    check(tag, 64'(sb_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  bit found;
  bit c_done;
  int b0;

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;

    // Reset values, with a command already offered
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel", 64'(bus.PSEL), 0);
    check("rst_penable", 64'(bus.PENABLE), 0);
    check("rst_pwrite", 64'(bus.PWRITE), 0);
    check("rst_paddr", 64'(bus.PADDR), 0);
    check("rst_pwdata", 64'(bus.PWDATA), 0);
    check("rst_pstrb", 64'(bus.PSTRB), 0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 0);
    check("rst_rsp_err", 64'(bus.rsp_err), 0);
    check("rst_rsp_timeout", 64'(bus.rsp_timeout), 0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    bus.cmd_valid = 1'b0;
    @(posedge PCLK);
    #1;

    // 1: write, PREADY on 4th ACCESS cycle, response one cycle after completion
    bus.rsp_ready = 1'b1;
    send(mk(8'h20, 1'b1, 32'hDEADBEEF, 4'hF, 4, 32'h0BADF00D, 1'b0));
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge PCLK);
      if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
        found = 1;
        check("t1_rsp_before_done", 64'(bus.rsp_valid), 0);
      end
    end
    check("t1_done_seen", 64'(found), 1);
    @(negedge PCLK);
    check("t1_rsp_latency", 64'(bus.rsp_valid), 1);
    @(posedge PCLK);
    #1;
    drain("t1_drain");

    // 2: read, PREADY on 2nd ACCESS cycle
    send(mk(8'h20, 1'b0, 32'h12345678, 4'hF, 2, 32'hDEADBEEF, 1'b0));
    drain("t2_drain");

    // 3: write to read-only region answered with PSLVERR
    send(mk(8'h05, 1'b1, 32'h000000A5, 4'h1, 1, 32'h0, 1'b1));
    drain("t3_drain");

    // 4: back-to-back transfers, FIFO fills, third command held until a pop
    bus.rsp_ready = 1'b0;
    b0 = b2b_cnt;
    send(mk(8'h10, 1'b1, 32'hA0A0A0A0, 4'h3, 1, 32'h0, 1'b0));
    send(mk(8'h11, 1'b0, 32'h0, 4'h0, 1, 32'h11111111, 1'b0));
    c_done = 0;
    fork
      begin
        send(mk(8'h12, 1'b0, 32'h0, 4'h0, 1, 32'h22222222, 1'b1));
        c_done = 1;
      end
    join_none
    repeat (6) @(posedge PCLK);
    @(negedge PCLK);
    check("t4_held_cmd_ready", 64'(bus.cmd_ready), 0);
    check("t4_held_psel", 64'(bus.PSEL), 0);
    check("t4_fifo_head_valid", 64'(bus.rsp_valid), 1);
    check("t4_b2b_count", 64'(b2b_cnt - b0), 1);
    @(posedge PCLK);
    #1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !c_done; i++) begin
      @(posedge PCLK);
      #1;
    end
    check("t4_third_sent", 64'(c_done), 1);
    drain("t4_drain");

    // 5: PREADY stuck low, watchdog abort
    send(mk(8'h30, 1'b0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0));
    drain("t5_drain");

    // 6: reset during ACCESS, then normal operation
    send(mk(8'h40, 1'b0, 32'h0, 4'h0, 0, 32'h55AA55AA, 1'b0));
    repeat (2) @(posedge PCLK);
    #1;
    check("t6_in_access", 64'(bus.PENABLE), 1);
    #1;
    PRESET = 1'b1;
    #1;
    check("t6_rst_psel", 64'(bus.PSEL), 0);
    check("t6_rst_penable", 64'(bus.PENABLE), 0);
    check("t6_rst_rsp_valid", 64'(bus.rsp_valid), 0);
    check("t6_rst_cmd_ready", 64'(bus.cmd_ready), 0);
    sb_q.delete();
    plan_q.delete();
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;
    send(mk(8'h41, 1'b1, 32'h13579BDF, 4'hC, 2, 32'h0, 1'b0));
    drain("t6_drain");
    repeat (3) @(posedge PCLK);
    #1;
    check("end_rsp_valid", 64'(bus.rsp_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
